// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // WAIT covers the single cycle after reset release, when memory data is not yet trustworthy.
  typedef enum logic [1:0] {
    WAIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Word-align a byte address by clearing its two low bits.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries. Flush beats push/pop; pointers wrap
// modulo DEPTH (a power of two). The head reads as zero when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          push_ok;
  logic          pop_ok;

  fetch_entry_t  mem_q [DEPTH];

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Next pointer/occupancy: flush empties, otherwise push and pop act independently.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  // NOTE: storage is deliberately not reset; occupancy is, and the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses a combinational instruction
// memory, buffers fetched words and hands them to decode via valid/ready.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned redirects halt the
// stage and raise a sticky misalign_err; without it the low PC bits are cleared).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pc_plus4,
  output logic        misalign_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;

  logic         q_push;
  logic         q_pop;
  logic         q_flush;
  logic         q_full;
  logic         q_empty;
  logic         handshake;
  fetch_entry_t q_head;
  fetch_entry_t q_in;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;
  assign misalign_err = misalign_q;
`else
  // Low redirect bits are intentionally discarded in this build.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign misalign_err         = 1'b0;
`endif

  assign imem_addr    = pc_q;
  assign q_in         = '{pc: pc_q, instr: imem_rdata};
  assign handshake    = dec_valid && dec_ready;

  // Decode-side outputs come straight from the registered queue head.
  assign dec_valid    = !q_empty;
  assign dec_instr    = q_head.instr;
  assign dec_pc       = q_head.pc;
  assign dec_pc_plus4 = q_empty ? '0 : q_head.pc + PC_STEP;

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst),
    .push     (q_push),
    .push_data(q_in),
    .pop      (q_pop),
    .flush    (q_flush),
    .full     (q_full),
    .empty    (q_empty),
    .head     (q_head)
  );

  // Next-state, PC update and queue control; a redirect overrides normal fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    q_push  = 1'b0;
    q_pop   = 1'b0;
    q_flush = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    misalign_d = misalign_q;
`endif

    unique case (state_q)
      WAIT: state_d = RUN;
      RUN: begin
        if (!redirect_valid) begin
          q_pop = handshake;
          if (!q_full || handshake) begin
            q_push = 1'b1;
            pc_d   = pc_q + PC_STEP;
          end
        end
      end
`ifdef FETCH_MISALIGN_CHK_EN
      HALT: begin
        // Stays here until reset; nothing is fetched or accepted.
      end
`endif
      default: state_d = WAIT;
    endcase

    if (redirect_valid && state_q != HALT) begin
      q_flush = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        pc_d       = redirect_pc;
        misalign_d = 1'b1;
        state_d    = HALT;
      end else begin
        pc_d = align_pc(redirect_pc);
      end
`else
      pc_d = align_pc(redirect_pc);
`endif
    end
  end

  // State, PC and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT;
      pc_q    <= RESET_PC;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef FETCH_MISALIGN_CHK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed start-up, back-pressure, redirect
// and wrap scenarios plus a randomized run against a queue-based reference model.
module tb_fetch_unit;

  localparam int unsigned QDEPTH = 2;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam bit          FEAT      = 1'b1;
  localparam logic [31:0] RAND_MASK = 32'hFFFF_FFFC;
`else
  localparam bit          FEAT      = 1'b0;
  localparam logic [31:0] RAND_MASK = 32'hFFFF_FFFF;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (RESET_PC = 0)
  logic        rst;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc, dec_pc_plus4;
  logic        misalign_err;

  // Wrap instance (RESET_PC near the top of the address space)
  logic        rst_w;
  logic [31:0] imem_addr_w, imem_rdata_w;
  logic        redirect_valid_w;
  logic [31:0] redirect_pc_w;
  logic        dec_valid_w, dec_ready_w;
  logic [31:0] dec_instr_w, dec_pc_w, dec_pc_plus4_w;
  logic        misalign_err_w;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0062_E233;
      32'h0000_0004: return 32'h0083_2383;
      default:       return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endcase
  endfunction

  // Memory output is held at zero while the fetch unit is in reset.
  assign imem_rdata   = rst   ? mem_word(imem_addr)   : 32'h0;
  assign imem_rdata_w = rst_w ? mem_word(imem_addr_w) : 32'h0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4), .misalign_err(misalign_err)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(QDEPTH)) dut_w (
    .clk(clk), .rst(rst_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
    .dec_valid(dec_valid_w), .dec_ready(dec_ready_w), .dec_instr(dec_instr_w),
    .dec_pc(dec_pc_w), .dec_pc_plus4(dec_pc_plus4_w), .misalign_err(misalign_err_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_wait, m_halt, m_mis;

  task automatic model_reset();
    m_q.delete();
    m_pc   = 32'h0;
    m_wait = 1'b1;
    m_halt = 1'b0;
    m_mis  = 1'b0;
  endtask

  task automatic model_compare();
    bit have = (m_q.size() > 0);
    check("dec_valid",    {31'b0, dec_valid},    {31'b0, have});
    check("dec_pc",       dec_pc,       have ? m_q[0].pc : 32'h0);
    check("dec_instr",    dec_instr,    have ? m_q[0].instr : 32'h0);
    check("dec_pc_plus4", dec_pc_plus4, have ? m_q[0].pc + 32'd4 : 32'h0);
    check("imem_addr",    imem_addr,    m_pc);
    check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
  endtask

  // Apply one clock's worth of the fetch rules to the model using current inputs.
  task automatic model_advance();
    bit   hs;
    bit   enq;
    ent_t e;
    if (!m_halt && redirect_valid) begin
      m_q.delete();
      if (FEAT && redirect_pc[1:0] != 2'b00) begin
        m_pc   = redirect_pc;
        m_mis  = 1'b1;
        m_halt = 1'b1;
      end else begin
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end
    end else if (!m_wait && !m_halt) begin
      hs  = (m_q.size() > 0) && dec_ready;
      enq = (m_q.size() < QDEPTH) || hs;
      e.pc    = m_pc;
      e.instr = mem_word(m_pc);
      if (hs)  void'(m_q.pop_front());
      if (enq) begin
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    m_wait = 1'b0;
  endtask

  // Called at a falling edge: compare, advance model, move to the next falling edge.
  task automatic step();
    #1;
    model_compare();
    model_advance();
    @(negedge clk);
  endtask

  task automatic main_reset();
    rst = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, dec_valid}, 32'h0);
    check("async_rst_pc",    imem_addr, 32'h0);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    rst_w = 1'b0; dec_ready_w = 1'b1; redirect_valid_w = 1'b0; redirect_pc_w = 32'h0;
    model_reset();

    // Start-up
    repeat (3) @(negedge clk);
    check("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
    check("rst_dec_instr", dec_instr, 32'h0);
    check("rst_dec_pc",    dec_pc, 32'h0);
    check("rst_misalign",  {31'b0, misalign_err}, 32'h0);
    rst = 1'b1;
    dec_ready = 1'b1;
    #1 check("wait_imem_addr", imem_addr, 32'h0);
    step();
    check("wait_no_valid", {31'b0, dec_valid}, 32'h0);
    step();
    check("first_valid", {31'b0, dec_valid}, 32'h1);
    check("first_pc",    dec_pc, 32'h0);
    check("first_instr", dec_instr, 32'h0062_E233);
    step();
    check("second_pc",    dec_pc, 32'h4);
    check("second_plus4", dec_pc_plus4, 32'h8);
    check("second_instr", dec_instr, 32'h0083_2383);

    // Back-pressure from a fresh start
    main_reset();
    dec_ready = 1'b0;
    repeat (5) step();
    check("bp_addr_frozen", imem_addr, 32'h8);
    check("bp_valid",       {31'b0, dec_valid}, 32'h1);
    dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_order", dec_pc, 32'(i * 4));
      step();
    end

    // Redirect with a full queue and a concurrent dequeue
    dec_ready = 1'b0;
    repeat (2) step();
    dec_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0;
    check("redir_flush_valid", {31'b0, dec_valid}, 32'h0);
    check("redir_addr",        imem_addr, 32'h100);
    step();
    check("redir_first_pc",    dec_pc, 32'h100);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    check("mis_err_set", {31'b0, misalign_err}, 32'h1);
    check("mis_addr",    imem_addr, 32'h102);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    repeat (3) step();
    check("halt_ignore_redir", imem_addr, 32'h102);
    check("halt_no_valid",     {31'b0, dec_valid}, 32'h0);
    check("halt_err_sticky",   {31'b0, misalign_err}, 32'h1);
    main_reset();
    check("mis_err_cleared", {31'b0, misalign_err}, 32'h0);
`else
    check("align_addr", imem_addr, 32'h100);
    check("align_err",  {31'b0, misalign_err}, 32'h0);
    step();
    check("align_pc", dec_pc, 32'h100);
`endif

    // Randomized run
    for (int i = 0; i < 800; i++) begin
      dec_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom & RAND_MASK;
      if ($urandom_range(0, 15) == 0) redirect_pc = 32'hFFFF_FFF0;
      if (i == 400) main_reset();
      step();
    end
    redirect_valid = 1'b0;

    // Wrap instance: start-up across the top of the address space
    rst_w = 1'b1;
    repeat (2) @(negedge clk);
    check("wrap_pc0",    dec_pc_w, 32'hFFFF_FFF8);
    check("wrap_plus0",  dec_pc_plus4_w, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_pc1",    dec_pc_w, 32'hFFFF_FFFC);
    check("wrap_plus1",  dec_pc_plus4_w, 32'h0000_0000);
    @(negedge clk);
    check("wrap_pc2",    dec_pc_w, 32'h0000_0000);
    check("wrap_instr2", dec_instr_w, 32'h0062_E233);
    check("wrap_err",    {31'b0, misalign_err_w}, 32'h0);
    @(posedge clk);
    #2 rst_w = 1'b0;
    #1;
    check("wrap_async_valid", {31'b0, dec_valid_w}, 32'h0);
    check("wrap_async_pc",    imem_addr_w, 32'hFFFF_FFF8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage; sits directly upstream of the instruction memory and downstream of nothing but reset and redirect sources.
- Owns the program counter, drives the word address into the combinational instruction memory, and captures the returned word.
- Buffers fetched words in a small queue and presents them to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and reloading the PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
QDEPTH, 2, fetch queue entries; power of two, minimum 2.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset asserted).
imem_addr  output  32  byte address to instruction memory; equals current PC, combinational from the PC register.
imem_rdata  input  32  instruction word returned combinationally for imem_addr.
redirect_valid  input  1  branch/jump taken this cycle.
redirect_pc  input  32  redirect target byte address.
dec_valid  output  1  queue head holds a valid instruction.
dec_ready  input  1  decode accepts the head this cycle.
dec_instr  output  32  head instruction word.
dec_pc  output  32  head instruction's PC.
dec_pc_plus4  output  32  dec_pc + 4, modulo 2^32.
misalign_err  output  1  sticky misaligned-redirect flag; tied 0 when the optional feature is absent.

Behaviour:
- Reset values: PC = RESET_PC; queue empty; dec_valid = 0; dec_instr, dec_pc, dec_pc_plus4 = 0; misalign_err = 0; state = WAIT.
- States:
  - WAIT: one cycle after reset release, no enqueue. This is required because memory output is forced to 0 during reset. Always transitions to RUN.
  - RUN: normal fetch operation.
  - HALT: entered only with the optional feature; exited only by reset.
- Enqueue rule, RUN: enqueue {PC, imem_rdata} and set PC <= PC + 4 when (queue not full) or (dec_valid and dec_ready in the same cycle). Otherwise PC holds and imem_addr stays stable.
- Dequeue: a handshake occurs when dec_valid and dec_ready are both high; the head pops at the clock edge.
- Simultaneous dequeue and enqueue on a full queue: both occur and occupancy is unchanged.
- Latency: a word addressed in cycle N appears at dec_* in cycle N+1 when the queue is empty. Sustained throughput is one instruction per cycle.
- Redirect (any state except HALT): has highest priority.
  - Queue is flushed to empty.
  - PC <= {redirect_pc[31:2], 2'b00}.
  - No enqueue that cycle; any concurrent dequeue is ignored.
  - dec_valid is 0 in the next cycle, and the first target instruction appears one cycle after that.
- Redirect during WAIT: the PC is loaded, and WAIT→RUN still proceeds.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- dec_* outputs are 0 whenever the queue is empty.
- dec_* outputs are driven from the queue head registers; there is no combinational path from imem_rdata to dec_*.
- Reset asserted mid-operation: immediate asynchronous return to the reset values; in-flight entries are lost.

Optional Feature:
FETCH_MISALIGN_CHK_EN
- Defined:
  - A redirect with redirect_pc[1:0] != 0 sets misalign_err = 1 (sticky) and flushes the queue.
  - The PC is loaded with the unaligned value, and the state moves to HALT.
  - In HALT: no enqueue, dec_valid = 0, and further redirects are ignored until reset.
- Undefined:
  - redirect_pc[1:0] is silently cleared.
  - misalign_err is tied to 0, and the HALT state is absent.

Decomposition:
- Package fetch_pkg:
  - RESET_PC default constant.
  - State enum {WAIT, RUN, HALT}.
  - Entry struct fetch_entry_t {pc[31:0], instr[31:0]}.
  - PC_STEP = 4.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, depth QDEPTH.
  - Ports: push, pop, flush, full, empty, head.
  - Flush has priority over push and pop.
  - Pointers wrap modulo QDEPTH.

Test Plan:
- Reset/start-up: rst low 3 cycles, then released with dec_ready = 1 and memory words 0→32'h0062E233, 4→32'h00832383.
  - imem_addr = 0 during WAIT.
  - dec_valid is first high at cycle 2 after release with dec_pc = 0, dec_instr = 32'h0062E233.
  - Next cycle: dec_pc = 4, dec_pc_plus4 = 8.
- Back-pressure: dec_ready = 0 for 5 cycles.
  - Queue fills to 2 entries and imem_addr freezes at 8.
  - On dec_ready = 1, PCs 0, 4, 8 are delivered in order with no loss or duplication.
- Redirect with queue full and a dequeue in the same cycle: redirect_pc = 32'h0000_0100.
  - Next cycle dec_valid = 0 and imem_addr = 0x100.
  - The following cycle dec_pc = 0x100.
- Redirect alignment with the feature off: redirect_pc = 32'h0000_0102.
  - imem_addr = 0x100 and misalign_err = 0.
- FETCH_MISALIGN_CHK_EN on: redirect_pc = 32'h0000_0102.
  - misalign_err = 1 next cycle and stays 1; dec_valid = 0 until reset.
  - A later redirect to 0x200 is ignored.
- Wrap and async reset: RESET_PC = 32'hFFFF_FFF8.
  - Delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - Asserting rst between clock edges clears dec_valid immediately, without waiting for a clock edge.
